seq_detect_ctrl: RTL and testbench
==================================

# seq_detect_ctrl

Run controller for the board's serial bit-pattern detectors. It latches a programmable pattern and sequences serial input bits through a valid/ready handshake. It counts pattern matches, with overlapping or non-overlapping detection, and stops after an optional bit budget. It drives the 7-segment run-state letter in the same active-low `st_literal` format the detector blocks use.

## Interface
- `PAT_W`, default 4: pattern length in bits, ≥2.
- `CNT_W`, default 8: match-counter width.
- `BIT_LIMIT`, default 0: bits accepted per run before auto-stop; 0 = unlimited.
- `PAT_RESET`, default 4'b1100: pattern register value after reset.
- `Clock`  in  1: single clock. All logic is on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a new run. Accepted in IDLE and DONE only.
- `stop`  in  1: end the run. Effective in RUN and HOLD.
- `pause`  in  1: level. While high in RUN/HOLD, the block holds.
- `overlap`  in  1: detection mode, latched at start.
- `cfg_pattern`  in  PAT_W: pattern, latched at start. The MSB is the first bit in time.
- `x`  in  1: serial data bit.
- `x_valid`  in  1: `x` is valid this cycle.
- `x_ready`  out  1: the block accepts a bit this cycle. Equals (state==RUN).
- `y`  out  1: one-cycle match pulse.
- `match_count`  out  CNT_W: matches this run, saturating.
- `busy`  out  1: state is RUN or HOLD.
- `st_literal`  out  8: active-low segments {dp,g,f,e,d,c,b,a} showing the state letter.

## Operation
- **States:** IDLE, RUN, HOLD, DONE.
- **IDLE/DONE, `start`=1:**
  - latch `cfg_pattern` into `pat_q` and `overlap` into `ovl_q`;
  - clear history, fill counter, bit counter and `match_count`;
  - go to RUN.
- **RUN/HOLD exits:**
  - RUN: `stop` → DONE; else `pause` → HOLD.
  - HOLD: `stop` → DONE; else `pause`=0 → RUN.
  - `stop` has priority over `pause`.
  - `start` is ignored in RUN and HOLD.
- **Bit accept** (`x_valid && x_ready`):
  - `hist_n = {hist[PAT_W-2:0], x}`.
  - Fill counter increments, saturating at PAT_W.
  - Bit counter increments.
  - Bits presented when `x_ready`=0 are dropped. They are not queued.
- **Match:** on an accept where `fill_n`==PAT_W and `hist_n`==`pat_q`:
  - `y`=1 for the following cycle;
  - `match_count` increments, holding at 2^CNT_W−1;
  - if `ovl_q`=0, the fill counter is cleared to 0 instead of incremented.
- **Bit budget:** when BIT_LIMIT≠0 and an accept brings the bit counter to BIT_LIMIT, the state goes to DONE. A match on that final bit still counts and still pulses `y`. The budget exit takes priority over `pause` on that same cycle.
- **`st_literal` per state:**
  - IDLE '-' = 8'hBF
  - RUN 'r' = 8'hAF
  - HOLD 'H' = 8'h89
  - DONE 'd' = 8'hA1
- **DONE:** holds `match_count` and `pat_q` until the next `start` or reset.

## Timing
- Every output is registered, except `x_ready` and `busy`, which decode the state register.
- **Reset values:**
  - state IDLE
  - `y`=0
  - `match_count`=0
  - `pat_q`=PAT_RESET
  - `ovl_q`=1
  - `st_literal`=8'hBF
  - `x_ready`=0
  - `busy`=0
- **Latencies:**
  - `start` at edge n → `x_ready`=1 in cycle n+1.
  - Matching accept at edge n → `y`=1 and the new `match_count` in cycle n+1.
- Back-to-back accepts are supported at 1 bit per cycle. `y` can then be high in consecutive cycles.
- `pause` or `stop` asserted in the same cycle as `x_valid` while in RUN: that bit is still accepted, because `x_ready` reflects the current state. The transition takes effect at the following edge.
- `Reset` overrides all inputs, including in the middle of a run. A match pulse pending from the accept on the reset edge is suppressed (`y`=0).

## Structure
- Package `seq_detect_pkg`:
  - `ctrl_state_t` enum for IDLE/RUN/HOLD/DONE;
  - segment constants `SEG_DASH`, `SEG_R`, `SEG_H`, `SEG_D`.
- Sub-module `seq_match_core`, parameterised by PAT_W. It holds the history shift register, fill counter and comparator, with inputs `clr`, `shift`, `x`, `pat`, `ovl` and a combinational `hit` output.
- `seq_detect_ctrl` owns the FSM, bit counter, match counter and `st_literal` decode.

## Test plan
1. **Reset.** Hold `Reset` 2 cycles. Expect IDLE, `st_literal`=8'hBF, `y`=0, `match_count`=0, `x_ready`=0.
2. **Overlap, pattern 1100.** Set `cfg_pattern`=1100, `overlap`=1, then `start`. Stream 1,1,0,0,1,1,0,0 with `x_valid` held high. Expect `y` pulses the cycle after bit 4 and the cycle after bit 8, and `match_count`=2.
3. **Overlap vs non-overlap, pattern 1010.** Stream 1,0,1,0,1,0.
   - `overlap`=1: matches at bits 4 and 6, count 2.
   - `overlap`=0: match at bit 4 only, count 1.
4. **Pause.** Assert `pause` after bit 2 of 1100 while keeping `x_valid`=1 for 3 cycles. Expect `st_literal`=8'h89 and no accepts during the pause. Release `pause`, then send 0,0. Expect a `y` pulse and count 1.
5. **Bit budget.** With BIT_LIMIT=8, send 10 bits. Expect DONE after bit 8, `x_ready`=0, `st_literal`=8'hA1, and bits 9–10 ignored. Issue `start` again: `match_count` returns to 0 and the state is RUN.
6. **Saturation and mid-run reset.**
   - With CNT_W=2, send 5 matches. Expect `match_count` to hold at 3.
   - Assert `Reset` on the edge that accepts a matching bit. Expect `y`=0, IDLE and `match_count`=0 next cycle.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the serial pattern detector run controller.
// No logic; the state encoding and segment codes are used by the controller.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } ctrl_state_t;

  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_R    = 8'hAF;
  localparam logic [7:0] SEG_H    = 8'h89;
  localparam logic [7:0] SEG_D    = 8'hA1;

  // Letter shown on the 7-segment digit for each run state.
  function automatic logic [7:0] seg_for_state(input ctrl_state_t s);
    case (s)
      ST_RUN:  seg_for_state = SEG_R;
      ST_HOLD: seg_for_state = SEG_H;
      ST_DONE: seg_for_state = SEG_D;
      default: seg_for_state = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_match.sv
// History shift register, fill counter and pattern comparator.
// Latency: hit is combinational on the shifting bit; state updates on the edge.
// Backpressure: none; the owner decides when to shift.
module seq_match_core #(
  parameter int PAT_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clr,
  input  logic             shift,
  input  logic             x,
  input  logic [PAT_W-1:0] pat,
  input  logic             ovl,
  output logic             hit
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_n;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_n;

  // Next history and saturating fill count for the bit being shifted in.
  always_comb begin
    hist_n = {hist[PAT_W-2:0], x};
    fill_n = (fill == FULL) ? fill : fill + 1'b1;
    hit    = shift && (fill_n == FULL) && (hist_n == pat);
  end

  // Shift on accept; a non-overlapping match restarts the fill so the
  // next match needs a full fresh window of bits.
  always_ff @(posedge Clock) begin
    if (Reset || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_n;
      fill <= (hit && !ovl) ? '0 : fill_n;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: latches a pattern, accepts serial bits, counts matches.
// Latency: start -> x_ready next cycle; matching accept -> y/match_count next cycle.
// Backpressure: x_ready is high only in RUN; bits offered otherwise are dropped.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int             PAT_W     = 4,
  parameter int             CNT_W     = 8,
  parameter int             BIT_LIMIT = 0,
  parameter logic [PAT_W-1:0] PAT_RESET = 4'b1100
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             overlap,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             x,
  input  logic             x_valid,
  output logic             x_ready,
  output logic             y,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic [7:0]       st_literal
);

  localparam bit LIMIT_EN = (BIT_LIMIT != 0);
  localparam int BCNT_W   = LIMIT_EN ? $clog2(BIT_LIMIT + 1) : 1;
  localparam logic [BCNT_W-1:0] BIT_LIM_V = BCNT_W'(BIT_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  ctrl_state_t       state, state_n;
  logic [PAT_W-1:0]  pat_q;
  logic              ovl_q;
  logic [BCNT_W-1:0] bit_cnt;
  logic [BCNT_W-1:0] bit_cnt_n;
  logic              start_acc;
  logic              accept;
  logic              budget_hit;
  logic              hit;

  assign x_ready = (state == ST_RUN);
  assign busy    = (state == ST_RUN) || (state == ST_HOLD);

  assign start_acc  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign accept     = x_valid && x_ready;
  assign bit_cnt_n  = bit_cnt + 1'b1;
  assign budget_hit = LIMIT_EN && accept && (bit_cnt_n == BIT_LIM_V);

  seq_match_core #(.PAT_W(PAT_W)) u_core (
    .Clock (Clock),
    .Reset (Reset),
    .clr   (start_acc),
    .shift (accept),
    .x     (x),
    .pat   (pat_q),
    .ovl   (ovl_q),
    .hit   (hit)
  );

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next state: stop beats budget beats pause; start only from IDLE/DONE.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_n = ST_RUN;
      ST_RUN: begin
        if (stop || budget_hit) state_n = ST_DONE;
        else if (pause)         state_n = ST_HOLD;
      end
      ST_HOLD: begin
        if (stop)        state_n = ST_DONE;
        else if (!pause) state_n = ST_RUN;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Run configuration, latched only when a run is started.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pat_q <= PAT_RESET;
      ovl_q <= 1'b1;
    end else if (start_acc) begin
      pat_q <= cfg_pattern;
      ovl_q <= overlap;
    end
  end

  // Bits accepted this run, for the budget exit.
  always_ff @(posedge Clock) begin
    if (Reset || start_acc) bit_cnt <= '0;
    else if (accept)        bit_cnt <= bit_cnt_n;
  end

  // Registered match pulse, saturating match counter and state letter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      y           <= 1'b0;
      match_count <= '0;
      st_literal  <= SEG_DASH;
    end else begin
      y          <= hit;
      st_literal <= seg_for_state(state_n);
      if (start_acc)
        match_count <= '0;
      else if (hit && (match_count != CNT_MAX))
        match_count <= match_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl (PAT_W=4, CNT_W=2, BIT_LIMIT=8).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Each scenario task carries its own expected values.
module tb_seq_detect_ctrl;

  logic       Clock = 1'b0;
  logic       Reset, start, stop, pause, overlap, x, x_valid;
  logic [3:0] cfg_pattern;
  logic       x_ready, y, busy;
  logic [1:0] match_count;
  logic [7:0] st_literal;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  seq_detect_ctrl #(
    .PAT_W(4), .CNT_W(2), .BIT_LIMIT(8), .PAT_RESET(4'b1100)
  ) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .stop(stop), .pause(pause),
    .overlap(overlap), .cfg_pattern(cfg_pattern), .x(x), .x_valid(x_valid),
    .x_ready(x_ready), .y(y), .match_count(match_count), .busy(busy),
    .st_literal(st_literal)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Leave any run via stop, then start a fresh one with the given config.
  task automatic start_run(input logic [3:0] p, input logic o);
    x_valid = 1'b0; pause = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    cfg_pattern = p; overlap = o; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (x_ready !== 1'b1 || match_count !== 2'd0 || st_literal !== 8'hAF) begin
      bad++;
      $display("FAIL start_run: x_ready=%b count=%0d seg=%h, want 1 0 af", x_ready, match_count, st_literal);
    end
  endtask

  // Stream n bits (MSB of bits first), checking y after each accept edge.
  task automatic stream(input string name, input int n, input logic [9:0] bits,
                        input logic [9:0] yexp);
    for (int i = 0; i < n; i++) begin
      x = bits[n-1-i]; x_valid = 1'b1;
      tick();
      total++;
      if (y !== yexp[n-1-i]) begin
        bad++;
        $display("FAIL %s y bit%0d: got %b want %b", name, i + 1, y, yexp[n-1-i]);
      end
    end
    x_valid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; start = 0; stop = 0; pause = 0; overlap = 0;
    cfg_pattern = 4'b0; x = 0; x_valid = 0;
    tick(); tick();
    Reset = 1'b0;
    total++;
    if (st_literal !== 8'hBF || y !== 1'b0 || match_count !== 2'd0 ||
        x_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: seg=%h y=%b cnt=%0d rdy=%b busy=%b, want bf 0 0 0 0",
               st_literal, y, match_count, x_ready, busy);
    end
  endtask

  task automatic test_overlap_1100();
    start_run(4'b1100, 1'b1);
    stream("ovl1100", 8, 10'b0011001100, 10'b0000010001);
    total++;
    if (match_count !== 2'd2) begin
      bad++; $display("FAIL ovl1100 count: got %0d want 2", match_count);
    end
  endtask

  task automatic test_overlap_modes();
    start_run(4'b1010, 1'b1);
    stream("ovl1010", 6, 10'b0000101010, 10'b0000000101);
    total++;
    if (match_count !== 2'd2) begin
      bad++; $display("FAIL ovl1010 count: got %0d want 2", match_count);
    end
    start_run(4'b1010, 1'b0);
    stream("novl1010", 6, 10'b0000101010, 10'b0000000100);
    total++;
    if (match_count !== 2'd1) begin
      bad++; $display("FAIL novl1010 count: got %0d want 1", match_count);
    end
  endtask

  task automatic test_pause();
    start_run(4'b1100, 1'b1);
    stream("pause_pre", 2, 10'b0000000011, 10'b0);
    pause = 1'b1; tick();
    total++;
    if (st_literal !== 8'h89 || busy !== 1'b1) begin
      bad++; $display("FAIL pause enter: seg=%h busy=%b want 89 1", st_literal, busy);
    end
    for (int i = 0; i < 3; i++) begin
      x = 1'b0; x_valid = 1'b1;
      tick();
      total++;
      if (x_ready !== 1'b0 || y !== 1'b0 || st_literal !== 8'h89) begin
        bad++;
        $display("FAIL pause hold%0d: rdy=%b y=%b seg=%h want 0 0 89", i, x_ready, y, st_literal);
      end
    end
    x_valid = 1'b0; pause = 1'b0; tick();
    total++;
    if (x_ready !== 1'b1 || st_literal !== 8'hAF) begin
      bad++; $display("FAIL pause release: rdy=%b seg=%h want 1 af", x_ready, st_literal);
    end
    stream("pause_post", 2, 10'b0000000000, 10'b0000000001);
    total++;
    if (match_count !== 2'd1) begin
      bad++; $display("FAIL pause count: got %0d want 1", match_count);
    end
  endtask

  task automatic test_budget();
    start_run(4'b1100, 1'b1);
    stream("budget", 8, 10'b0011001100, 10'b0000010001);
    total++;
    if (x_ready !== 1'b0 || st_literal !== 8'hA1 || busy !== 1'b0) begin
      bad++; $display("FAIL budget done: rdy=%b seg=%h busy=%b want 0 a1 0", x_ready, st_literal, busy);
    end
    stream("budget_extra", 2, 10'b0000000011, 10'b0);
    total++;
    if (match_count !== 2'd2 || st_literal !== 8'hA1) begin
      bad++; $display("FAIL budget extra: cnt=%0d seg=%h want 2 a1", match_count, st_literal);
    end
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if (match_count !== 2'd0 || x_ready !== 1'b1 || st_literal !== 8'hAF) begin
      bad++; $display("FAIL budget restart: cnt=%0d rdy=%b seg=%h want 0 1 af", match_count, x_ready, st_literal);
    end
  endtask

  task automatic test_saturate_and_reset();
    start_run(4'b1111, 1'b1);
    stream("sat", 8, 10'b0011111111, 10'b0000011111);
    total++;
    if (match_count !== 2'd3) begin
      bad++; $display("FAIL saturate count: got %0d want 3", match_count);
    end
    start_run(4'b1100, 1'b1);
    stream("rst_pre", 3, 10'b0000000110, 10'b0);
    x = 1'b0; x_valid = 1'b1; Reset = 1'b1;
    tick();
    Reset = 1'b0; x_valid = 1'b0;
    total++;
    if (y !== 1'b0 || x_ready !== 1'b0 || match_count !== 2'd0 || st_literal !== 8'hBF) begin
      bad++;
      $display("FAIL midrun reset: y=%b rdy=%b cnt=%0d seg=%h want 0 0 0 bf", y, x_ready, match_count, st_literal);
    end
  endtask

  initial begin
    test_reset();
    test_overlap_1100();
    test_overlap_modes();
    test_pause();
    test_budget();
    test_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
